mips_dmem_bus_master: RTL and testbench
=======================================

// Module: mips_dmem_bus_master
// PURPOSE
//  M-stage initiator for the data-memory bus. Turns LW/SW requests from M into req/gnt/rvalid bus transactions.
//  Stalls the pipeline while a transaction is outstanding.
//  Produces data_mem_bus_rd_data_m/_w/_w_plus1, the load values consumed by the forwarding unit and by WB.
// PARAMETERS
//  DATA_W    32  bus and register data width
//  ADDR_W    32  byte address width
//  MAX_WAIT  16  cycles allowed in REQ or WAIT_R before timeout (>=2)
// PORTS
//  clk                           in   1       pipeline clock
//  rst                           in   1       asynchronous reset, active-low
//  req_valid_m                   in   1       M stage holds LW or SW
//  req_we_m                      in   1       1=SW, 0=LW
//  req_addr_m                    in   ADDR_W  byte address
//  req_wdata_m                   in   DATA_W  store data (reg_file_2_alu_2_m)
//  bus_req                       out  1       request to memory
//  bus_we                        out  1       write enable
//  bus_addr                      out  ADDR_W  word address; [1:0] forced 0
//  bus_wdata                     out  DATA_W  write data
//  bus_gnt                       in   1       request accepted
//  bus_rvalid                    in   1       read data valid
//  bus_rdata                     in   DATA_W  read data
//  bus_err                       in   1       error; qualified by bus_rvalid
//  stall                         out  1       freeze F/D/E/M and this block's W regs
//  data_mem_bus_rd_data_m        out  DATA_W  load data for the M instruction
//  data_mem_bus_rd_data_w        out  DATA_W  load data, one stage later
//  data_mem_bus_rd_data_w_plus1  out  DATA_W  load data, two stages later
//  err_pulse                     out  1       1-cycle pulse: bus_err, timeout or misalign
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FSM=IDLE; all outputs 0; wait counter 0; captured fields 0.
//   - Any rvalid still in flight is ignored after reset.
//  FSM states: IDLE, REQ, WAIT_R, DONE.
//   IDLE:
//    - req_valid_m=1 and addr[1:0]==0: latch we/addr/wdata, go to REQ.
//    - req_valid_m=1 and addr[1:0]!=0: go to DONE with rd_q=0 and err set; no bus traffic.
//    - stall = req_valid_m (combinational).
//   REQ:
//    - bus_req=1; bus_we/addr/wdata driven from latched values, stable until gnt; stall=1.
//    - On gnt: SW goes to DONE; LW goes to WAIT_R.
//   WAIT_R:
//    - stall=1; bus_req=0.
//    - On rvalid: rd_q <= bus_err ? 0 : bus_rdata; err <= bus_err; go to DONE.
//    - rvalid is only sampled in WAIT_R; rvalid in the gnt cycle is ignored.
//   DONE:
//    - stall=0; err_pulse=err; then go to IDLE unconditionally.
//    - The next M instruction is therefore evaluated in IDLE; no request is issued directly from DONE.
//   Timeout: counter clears on entry to REQ and to WAIT_R, increments each cycle in those states.
//    - Count reaching MAX_WAIT-1 without gnt/rvalid: go to DONE, rd_q=0, err=1.
//    - A later stray rvalid is ignored.
//  data_mem_bus_rd_data_m = rd_q (registered, holds last value).
//   - SW and misaligned accesses leave the prior load value in rd_q, except misalign, which forces 0.
//  W pipeline: on each edge with stall=0, _w <= _m and _w_plus1 <= _w; both hold while stall=1.
//  Latency (zero-wait bus):
//   - LW: IDLE->REQ->WAIT_R->DONE, stall high 3 cycles.
//   - SW: IDLE->REQ->DONE, stall high 2 cycles.
//  Back-to-back loads: second request goes out at the earliest 2 cycles after the first's DONE; no overlap.
//  Only one transaction is outstanding at any time. bus_req is never asserted in IDLE, WAIT_R or DONE.
// TESTING
//  - Reset: rst=0 mid-WAIT_R -> FSM IDLE, stall=0, bus_req=0, rd outputs 0; later rvalid ignored.
//  - LW, zero-wait: addr 0x100, gnt in 1st REQ cycle, rdata 0xCAFEBABE next cycle
//    -> stall 3 cycles, _m=0xCAFEBABE in DONE, _w next edge, _w_plus1 edge after.
//  - SW, 3 wait states: addr 0x204, wdata 0x12345678, gnt after 3 cycles
//    -> bus fields stable until gnt, bus_we=1, stall 5 cycles, rd_q unchanged.
//  - Timeout: MAX_WAIT=16, gnt never asserted -> DONE after 16 REQ cycles, err_pulse=1, _m=0.
//  - Error/misalign: rvalid with bus_err=1 -> _m=0, err_pulse=1.
//    addr 0x102 -> no bus_req, err_pulse=1, stall 1 cycle.
//  - Back-to-back LW (0xAA then 0xBB): _w_plus1=0xAA at the same time _w=0xBB; no value skipped or duplicated.

Source files
------------

// File: rtl/mips_dmem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mips_dmem_bus_master
// Description : M-stage data-memory bus initiator (req/gnt/rvalid) with
//               pipeline stall, timeout/misalign error pulse and load data
//               delayed into the W and W+1 stages.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_bus_master #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_m,
    input  logic              req_we_m,
    input  logic [ADDR_W-1:0] req_addr_m,
    input  logic [DATA_W-1:0] req_wdata_m,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_err,
    output logic              stall,
    output logic [DATA_W-1:0] data_mem_bus_rd_data_m,
    output logic [DATA_W-1:0] data_mem_bus_rd_data_w,
    output logic [DATA_W-1:0] data_mem_bus_rd_data_w_plus1,
    output logic              err_pulse
);

    localparam int                CNT_W    = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-3:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rd_w_q;
    logic [DATA_W-1:0]   rd_w1_q;
    logic                misalign;

    assign misalign = (req_addr_m[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = '0;
        rd_d    = rd_q;
        err_d   = err_q;
        bus_req = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req_valid_m;
                if (req_valid_m) begin
                    if (misalign) begin
                        // Misaligned access is rejected locally, no bus traffic.
                        state_d = DONE;
                        rd_d    = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        we_d    = req_we_m;
                        addr_d  = req_addr_m[ADDR_W-1:2];
                        wdata_d = req_wdata_m;
                        err_d   = 1'b0;
                    end
                end
            end
            REQ: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (bus_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? DONE : WAIT_R;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    rd_d    = '0;
                    err_d   = 1'b1;
                end
            end
            WAIT_R: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_rvalid) begin
                    state_d = DONE;
                    rd_d    = bus_err ? '0 : bus_rdata;
                    err_d   = bus_err;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    rd_d    = '0;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Load data follows the instruction down the pipe only when it advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_w_q  <= '0;
            rd_w1_q <= '0;
        end else if (!stall) begin
            rd_w_q  <= rd_q;
            rd_w1_q <= rd_w_q;
        end
    end

    assign bus_we                       = we_q;
    assign bus_addr                     = {addr_q, 2'b00};
    assign bus_wdata                    = wdata_q;
    assign err_pulse                    = (state_q == DONE) && err_q;
    assign data_mem_bus_rd_data_m       = rd_q;
    assign data_mem_bus_rd_data_w       = rd_w_q;
    assign data_mem_bus_rd_data_w_plus1 = rd_w1_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_dmem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_dmem_bus_master
// Description : Self-checking bench for mips_dmem_bus_master: transaction
//               table with a scoreboard, plus hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_dmem_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_m;
    logic        req_we_m;
    logic [31:0] req_addr_m;
    logic [31:0] req_wdata_m;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        stall;
    logic [31:0] rd_m;
    logic [31:0] rd_w;
    logic [31:0] rd_w1;
    logic        err_pulse;

    always #5 clk = ~clk;

    mips_dmem_bus_master #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .MAX_WAIT (16)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .req_valid_m                  (req_valid_m),
        .req_we_m                     (req_we_m),
        .req_addr_m                   (req_addr_m),
        .req_wdata_m                  (req_wdata_m),
        .bus_req                      (bus_req),
        .bus_we                       (bus_we),
        .bus_addr                     (bus_addr),
        .bus_wdata                    (bus_wdata),
        .bus_gnt                      (bus_gnt),
        .bus_rvalid                   (bus_rvalid),
        .bus_rdata                    (bus_rdata),
        .bus_err                      (bus_err),
        .stall                        (stall),
        .data_mem_bus_rd_data_m       (rd_m),
        .data_mem_bus_rd_data_w       (rd_w),
        .data_mem_bus_rd_data_w_plus1 (rd_w1),
        .err_pulse                    (err_pulse)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gw;        // REQ cycles before gnt (255 = never)
        int          rw;        // WAIT_R cycles before rvalid (255 = never)
        logic [31:0] rdata;
        logic        berr;
        int          exp_stall;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_reqc;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stall;
        int          reqc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[13];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_rd, m_w, m_w1;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input int gw, input int rw, input logic [31:0] rdata, input logic berr,
                                input int es, input logic [31:0] erd, input logic eerr, input int ereq);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.gw = gw; v.rw = rw;
        v.rdata = rdata; v.berr = berr; v.exp_stall = es; v.exp_rd = erd;
        v.exp_err = eerr; v.exp_reqc = ereq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic bus_idle();
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid_m = 1'b0;
            bus_idle();
            #1;
            chk("idle_stall", stall, 0);
            @(posedge clk); #1;
            m_w1 = m_w;
            m_w  = m_rd;
        end
    endtask

    task automatic run_txn(input int id, input vec_t v);
        exp_t e;
        int   cyc = 0, stall_cnt = 0, reqc = 0, rvc = 0;
        bit   rv_pend = 0, fields_ok = 1, pulse_ok = 1, done = 0;
        e.rd = v.exp_rd; e.err = v.exp_err; e.stall = v.exp_stall; e.reqc = v.exp_reqc;
        sb.push_back(e);
        req_valid_m = 1'b1; req_we_m = v.we; req_addr_m = v.addr; req_wdata_m = v.wdata;
        while (!done && cyc < 64) begin
            bus_idle();
            #1;
            if (bus_req) begin
                if (bus_addr !== {v.addr[31:2], 2'b00} || bus_we !== v.we || bus_wdata !== v.wdata)
                    fields_ok = 0;
                if (reqc == v.gw) begin
                    bus_gnt = 1'b1; rv_pend = !v.we; rvc = 0;
                end
                reqc++;
            end else if (rv_pend) begin
                if (rvc == v.rw) begin
                    bus_rvalid = 1'b1; bus_rdata = v.rdata; bus_err = v.berr; rv_pend = 0;
                end else rvc++;
            end
            #1;
            if (stall) begin
                stall_cnt++;
                if (err_pulse) pulse_ok = 0;
                @(posedge clk); #1;
                cyc++;
            end else done = 1;
        end
        e = sb.pop_front();
        if (!done) begin
            n_chk++;
            $display("FAIL txn%0d_done: stall never dropped, got %0d cycles required %0d", id, stall_cnt, e.stall);
            req_valid_m = 1'b0;
            bus_idle();
        end else begin
            chk($sformatf("txn%0d_stall_cycles", id), stall_cnt, e.stall);
            chk($sformatf("txn%0d_rd_m", id), rd_m, e.rd);
            chk($sformatf("txn%0d_err_pulse", id), err_pulse, e.err);
            chk($sformatf("txn%0d_req_cycles", id), reqc, e.reqc);
            chk($sformatf("txn%0d_bus_fields", id), fields_ok, 1);
            chk($sformatf("txn%0d_no_early_pulse", id), pulse_ok, 1);
            m_rd = e.rd;
            @(posedge clk); #1;
            req_valid_m = 1'b0;
            bus_idle();
            m_w1 = m_w;
            m_w  = m_rd;
            chk($sformatf("txn%0d_rd_w", id), rd_w, m_w);
            chk($sformatf("txn%0d_rd_w_plus1", id), rd_w1, m_w1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid_m = 1'b0; req_we_m = 1'b0; req_addr_m = '0; req_wdata_m = '0;
        bus_idle();
        m_rd = '0; m_w = '0; m_w1 = '0;

        vecs[0]  = mk(1'b0, 32'h100, 32'h0,        0,   0,   32'hCAFEBABE, 1'b0, 3,  32'hCAFEBABE, 1'b0, 1);
        vecs[1]  = mk(1'b1, 32'h204, 32'h12345678, 3,   0,   32'h0,        1'b0, 5,  32'hCAFEBABE, 1'b0, 4);
        vecs[2]  = mk(1'b0, 32'h010, 32'h0,        0,   0,   32'hAA,       1'b0, 3,  32'hAA,       1'b0, 1);
        vecs[3]  = mk(1'b0, 32'h014, 32'h0,        0,   0,   32'hBB,       1'b0, 3,  32'hBB,       1'b0, 1);
        vecs[4]  = mk(1'b0, 32'h300, 32'h0,        1,   2,   32'hDEADBEEF, 1'b0, 6,  32'hDEADBEEF, 1'b0, 2);
        vecs[5]  = mk(1'b0, 32'h400, 32'h0,        0,   0,   32'h55555555, 1'b1, 3,  32'h0,        1'b1, 1);
        vecs[6]  = mk(1'b0, 32'h500, 32'h0,        0,   0,   32'h11111111, 1'b0, 3,  32'h11111111, 1'b0, 1);
        vecs[7]  = mk(1'b0, 32'h102, 32'h0,        0,   0,   32'h77777777, 1'b0, 1,  32'h0,        1'b1, 0);
        vecs[8]  = mk(1'b0, 32'h600, 32'h0,        0,   0,   32'h22222222, 1'b0, 3,  32'h22222222, 1'b0, 1);
        vecs[9]  = mk(1'b1, 32'h700, 32'h0F0F0F0F, 255, 0,   32'h0,        1'b0, 17, 32'h0,        1'b1, 16);
        vecs[10] = mk(1'b0, 32'h800, 32'h0,        0,   0,   32'h33333333, 1'b0, 3,  32'h33333333, 1'b0, 1);
        vecs[11] = mk(1'b0, 32'h900, 32'h0,        0,   255, 32'h44444444, 1'b0, 18, 32'h0,        1'b1, 1);
        vecs[12] = mk(1'b1, 32'hA04, 32'hA5A5A5A5, 0,   0,   32'h0,        1'b0, 2,  32'h0,        1'b0, 1);

        // Reset state
        @(posedge clk); #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rd_m", rd_m, 0);
        chk("rst_rd_w", rd_w, 0);
        chk("rst_rd_w_plus1", rd_w1, 0);
        chk("rst_err_pulse", err_pulse, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycles(2);

        for (int i = 0; i < 13; i++) run_txn(i, vecs[i]);
        idle_cycles(2);

        // rvalid coincident with gnt must be ignored; the next one is taken
        req_valid_m = 1'b1; req_we_m = 1'b0; req_addr_m = 32'h40; req_wdata_m = '0;
        @(posedge clk); #1;
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
        #1;
        chk("gntrv_bus_req", bus_req, 1);
        @(posedge clk); #1;
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h600D600D;
        #1;
        chk("gntrv_wait_stall", stall, 1);
        @(posedge clk); #1;
        bus_idle();
        #1;
        chk("gntrv_done_stall", stall, 0);
        chk("gntrv_rd_m", rd_m, 32'h600D600D);
        m_rd = 32'h600D600D;
        @(posedge clk); #1;
        req_valid_m = 1'b0;
        m_w1 = m_w; m_w = m_rd;
        chk("gntrv_rd_w", rd_w, m_w);
        idle_cycles(1);

        // Asynchronous reset while waiting for read data; later rvalid is stray
        req_valid_m = 1'b1; req_we_m = 1'b0; req_addr_m = 32'h80;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        #1;
        chk("midrst_in_wait_stall", stall, 1);
        chk("midrst_in_wait_req", bus_req, 0);
        #1;
        rst = 1'b0;
        req_valid_m = 1'b0;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_bus_req", bus_req, 0);
        chk("midrst_rd_m", rd_m, 0);
        chk("midrst_rd_w", rd_w, 0);
        chk("midrst_rd_w_plus1", rd_w1, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        m_rd = '0; m_w = '0; m_w1 = '0;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_idle();
        #1;
        chk("stray_rv_rd_m", rd_m, 0);
        chk("stray_rv_stall", stall, 0);
        chk("stray_rv_err_pulse", err_pulse, 0);
        idle_cycles(1);

        // One more load after reset to show the block is live again
        run_txn(13, mk(1'b0, 32'hC0, 32'h0, 0, 0, 32'h13579BDF, 1'b0, 3, 32'h13579BDF, 1'b0, 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
